ahbl_burst_master: RTL and testbench
====================================

# ahbl_burst_master

AHB-Lite initiator that converts a simple command/data-beat interface into AHB-Lite SINGLE, INCR4, INCR8 and INCR16 transfers. It drives the same bus that our LSRAM AHB slave interface answers. It sits between internal engines (bootloader copy, UART bridge) and the AHB fabric. It handles pipelined address/data phases, slave wait states, write-data starvation via BUSY, and two-cycle ERROR termination.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 supported
- HCLK  in  1  sole clock
- HRESET  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  start byte address, aligned to cmd_size
- cmd_size  in  3  HSIZE: 0 = byte, 1 = half, 2 = word; others rejected
- cmd_len  in  2  0 = SINGLE, 1 = INCR4, 2 = INCR8, 3 = INCR16
- wr_valid / wr_ready / wr_data  in / out / 32  write-beat handshake
- rd_valid / rd_data  out / out / 32  read beat; no backpressure
- done  out  1  one-cycle pulse at command end
- err  out  1  valid with done; 1 = ERROR response or rejected command
- HTRANS 2, HADDR 32, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HWDATA 32  out  AHB master outputs; all registered
- HREADY 1, HRESP 1, HRDATA 32  in  AHB inputs

## Operation
- States: IDLE, ADDR (issuing beats), DRAIN (last data phase outstanding), ERR2 (second ERROR cycle).
- Accept: cmd_valid & cmd_ready. Latch the fields. beats = 1/4/8/16. HBURST = 000/011/101/111.
- Reject: cmd_size > 2, or the burst crosses a 1 KB boundary (addr[9:0] + beats<<size > 1024). No bus activity. done=1, err=1 on the next cycle; return to IDLE.
- Address increment per beat: 1<<size. HADDR[31:10] is never modified.
- HPROT fixed 4'b0011.
- Write data path:
  - One holding register. wr_ready = holding empty & write beats left to fetch > 0.
  - An address phase for beat n is issued only with the holding register full.
  - When that address phase is accepted (HREADY=1), holding moves to the HWDATA register and empties.
- Issue rule in ADDR:
  - Beat 0 is NONSEQ. Later beats are SEQ.
  - If data is not ready: before beat 0, drive IDLE; mid-burst, drive BUSY. Address and control are held during BUSY.
  - Reads never stall.
- Outputs change only when HREADY=1, except for the ERROR cancel.
- After the last address phase is accepted: HTRANS=IDLE, go to DRAIN.
- DRAIN: on HREADY=1 & HRESP=0, done=1, err=0, go to IDLE.
- Reads: rd_valid=1 with rd_data=HRDATA on each data phase completing with HREADY=1 & HRESP=0.
- ERROR:
  - HRESP=1 & HREADY=0 seen in ADDR or DRAIN: drive HTRANS=IDLE next cycle (cancels remaining beats); go to ERR2.
  - ERR2 on HREADY=1: done=1, err=1, holding register cleared, go to IDLE.
  - No rd_valid for the errored beat.
- Any HRESET=1 cycle: all state returns to reset values immediately on that edge, including mid-burst. No done pulse.

## Timing
- Reset values:
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0011, HWDATA=0
  - cmd_ready=1 (IDLE), wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0
- Read accepted at edge T: NONSEQ at T+1.
  - Zero wait states: one beat per cycle; first rd_valid at T+2; done at T+1+beats.
- Write accepted at T, wr_valid=1 continuously:
  - wr_ready=1 at T+1; NONSEQ at T+2.
  - Beat k's data appears on HWDATA one cycle after its address phase is accepted.
- Each wait state (HREADY=0) stretches the current phase by one cycle. All outputs are held.
- Throughput: one beat per cycle only if wr_valid is high on the cycle after each acceptance. Otherwise BUSY is inserted.

## Test plan
- SINGLE read, addr 0x100, size 2, slave returns 0xDEADBEEF with no waits -> NONSEQ/0x100/HBURST=000 at T+1; rd_valid with 0xDEADBEEF at T+2; done=1, err=0 at T+2.
- INCR4 word write at 0x2000, data 1..4, two wait states on beat 2 -> HADDR 0x2000/04/08/0C; HTRANS NONSEQ,SEQ,SEQ,SEQ; HWDATA 1..4 in order; done at end with err=0.
- INCR8 halfword write with wr_valid dropped for 3 cycles after beat 3 -> 3 BUSY cycles with HADDR held at the beat-4 address; addresses step by 2; no beats lost.
- INCR16 read with ERROR on beat 5 -> HTRANS=IDLE in the second ERROR cycle; exactly 5 rd_valid pulses; done=1, err=1.
- Command at 0x3F8, INCR4 word (crosses 1 KB) -> HTRANS stays IDLE; done=1, err=1 one cycle after accept. Also cmd_size=3 -> same response.
- HRESET asserted during beat 6 of INCR8 -> HTRANS=00 and cmd_ready=1 next cycle; no done pulse; a new SINGLE read then completes normally.

Source files
------------

// File: rtl/ahbl_burst_master.sv
// AHB-Lite initiator: turns a command plus write/read beat streams into
// SINGLE/INCR4/INCR8/INCR16 transfers with wait-state, BUSY and ERROR handling.
module ahbl_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            HTRANS,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DRAIN, ST_ERR2} state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              htrans_reg, htrans_next;
    logic [ADDR_WIDTH-1:0]   haddr_reg, haddr_next;
    logic                    hwrite_reg, hwrite_next;
    logic [2:0]              hsize_reg, hsize_next;
    logic [2:0]              hburst_reg, hburst_next;
    logic [DATA_WIDTH-1:0]   hwdata_reg, hwdata_next;
    logic [DATA_WIDTH-1:0]   hold_reg, hold_next;
    logic                    hold_full_reg, hold_full_next;
    logic [4:0]              issue_rem_reg, issue_rem_next;
    logic [4:0]              fetch_rem_reg, fetch_rem_next;
    logic                    dphase_reg, dphase_next;
    logic                    rej_reg, rej_next;

    logic [4:0]  cmd_beats;
    logic [2:0]  cmd_burst;
    logic [11:0] span_end;
    logic        cmd_bad;
    logic        addr_acc, hold_leave, wr_fire, data_ok, dphase_err;
    logic [9:0]  haddr_inc;

    always_comb begin
        cmd_beats = 5'd16;
        cmd_burst = 3'b111;
        case (cmd_len)
            2'd0:    begin cmd_beats = 5'd1; cmd_burst = 3'b000; end
            2'd1:    begin cmd_beats = 5'd4; cmd_burst = 3'b011; end
            2'd2:    begin cmd_beats = 5'd8; cmd_burst = 3'b101; end
            default: begin cmd_beats = 5'd16; cmd_burst = 3'b111; end
        endcase
    end

    // A burst may end exactly on the 1 KB boundary but not past it.
    assign span_end  = {2'b00, cmd_addr[9:0]} + (12'(cmd_beats) << cmd_size[1:0]);
    assign cmd_bad   = (cmd_size > 3'd2) || (span_end > 12'd1024);

    assign addr_acc   = htrans_reg[1] & HREADY;
    assign hold_leave = addr_acc & hwrite_reg;
    assign wr_ready   = (state_reg == ST_ADDR) && (!hold_full_reg || hold_leave)
                        && (fetch_rem_reg != 5'd0);
    assign wr_fire    = wr_valid & wr_ready;
    // Next beat may be issued when its data is in (or entering) the holding register.
    assign data_ok    = !hwrite_reg || wr_fire || (hold_full_reg && !hold_leave);
    assign dphase_err = dphase_reg & HRESP & ~HREADY;
    assign haddr_inc  = 10'd1 << hsize_reg[1:0];

    always_comb begin
        state_next     = state_reg;
        htrans_next    = htrans_reg;
        haddr_next     = haddr_reg;
        hwrite_next    = hwrite_reg;
        hsize_next     = hsize_reg;
        hburst_next    = hburst_reg;
        hwdata_next    = hwdata_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        issue_rem_next = issue_rem_reg;
        fetch_rem_next = fetch_rem_reg;
        dphase_next    = dphase_reg;
        rej_next       = 1'b0;

        if (HREADY) begin
            dphase_next = addr_acc;
        end
        if (hold_leave) begin
            hwdata_next    = hold_reg;
            hold_full_next = 1'b0;
        end
        if (wr_fire) begin
            hold_next      = wr_data;
            hold_full_next = 1'b1;
            fetch_rem_next = fetch_rem_reg - 5'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        rej_next = 1'b1;
                    end else begin
                        haddr_next     = cmd_addr;
                        hwrite_next    = cmd_write;
                        hsize_next     = cmd_size;
                        hburst_next    = cmd_burst;
                        issue_rem_next = cmd_beats;
                        fetch_rem_next = cmd_write ? cmd_beats : 5'd0;
                        hold_full_next = 1'b0;
                        htrans_next    = cmd_write ? TR_IDLE : TR_NONSEQ;
                        state_next     = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (dphase_err) begin
                    htrans_next = TR_IDLE;
                    state_next  = ST_ERR2;
                end else if (HREADY) begin
                    if (addr_acc) begin
                        issue_rem_next = issue_rem_reg - 5'd1;
                        if (issue_rem_reg == 5'd1) begin
                            htrans_next = TR_IDLE;
                            state_next  = ST_DRAIN;
                        end else begin
                            // BUSY already carries the next beat's address.
                            haddr_next  = {haddr_reg[ADDR_WIDTH-1:10], haddr_reg[9:0] + haddr_inc};
                            htrans_next = data_ok ? TR_SEQ : TR_BUSY;
                        end
                    end else if (data_ok) begin
                        htrans_next = (htrans_reg == TR_BUSY) ? TR_SEQ : TR_NONSEQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (dphase_err) begin
                    state_next = ST_ERR2;
                end else if (HREADY) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR2: begin
                if (HREADY) begin
                    state_next     = ST_IDLE;
                    hold_full_next = 1'b0;
                    fetch_rem_next = 5'd0;
                    issue_rem_next = 5'd0;
                    dphase_next    = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg     <= ST_IDLE;
            htrans_reg    <= TR_IDLE;
            haddr_reg     <= '0;
            hwrite_reg    <= 1'b0;
            hsize_reg     <= 3'd0;
            hburst_reg    <= 3'd0;
            hwdata_reg    <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            issue_rem_reg <= 5'd0;
            fetch_rem_reg <= 5'd0;
            dphase_reg    <= 1'b0;
            rej_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            htrans_reg    <= htrans_next;
            haddr_reg     <= haddr_next;
            hwrite_reg    <= hwrite_next;
            hsize_reg     <= hsize_next;
            hburst_reg    <= hburst_next;
            hwdata_reg    <= hwdata_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            issue_rem_reg <= issue_rem_next;
            fetch_rem_reg <= fetch_rem_next;
            dphase_reg    <= dphase_next;
            rej_reg       <= rej_next;
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign HTRANS    = htrans_reg;
    assign HADDR     = haddr_reg;
    assign HWRITE    = hwrite_reg;
    assign HSIZE     = hsize_reg;
    assign HBURST    = hburst_reg;
    assign HPROT     = 4'b0011;
    assign HWDATA    = hwdata_reg;

    // Completion and read strobes are suppressed in a reset cycle so no stray pulse escapes.
    assign rd_valid = ~HRESET & dphase_reg & HREADY & ~HRESP & ~hwrite_reg;
    assign rd_data  = rd_valid ? HRDATA : '0;
    assign done     = ~HRESET & (rej_reg
                      | ((state_reg == ST_DRAIN) & HREADY)
                      | ((state_reg == ST_ERR2) & HREADY));
    assign err      = ~HRESET & (rej_reg
                      | ((state_reg == ST_DRAIN) & HREADY & HRESP)
                      | ((state_reg == ST_ERR2) & HREADY));
endmodule

// File: tb/tb_ahbl_burst_master.sv
// Directed bench for ahbl_burst_master: the bench plays the AHB slave cycle by
// cycle and compares every bus and handshake output against hand-derived tables.
module tb_ahbl_burst_master;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done, err;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;

    int          n_checks = 0;
    int          n_pass = 0;
    int          wr_idx, wr_total;
    logic [31:0] wr_base;
    logic        wr_fire_prev;

    always #5 HCLK = ~HCLK;

    ahbl_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [1:0] len, input logic [31:0] base);
        next_cycle();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_len = len;
        wr_valid = 1'b0; wr_idx = 0; wr_fire_prev = 1'b0; wr_base = base;
        case (len)
            2'd0:    wr_total = 1;
            2'd1:    wr_total = 4;
            2'd2:    wr_total = 8;
            default: wr_total = 16;
        endcase
        if (!wr) wr_total = 0;
        #2;
        check("cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    // One bus cycle: drive slave response and write feeder, then compare outputs.
    task automatic bus_cycle(input string tag, input logic rdy, input logic resp,
                             input logic [31:0] rdata, input logic wstall,
                             input logic [1:0] e_trans, input logic [31:0] e_addr,
                             input logic e_wd_chk, input logic [31:0] e_wd,
                             input logic e_rdv, input logic [31:0] e_rd,
                             input logic e_done, input logic e_err);
        next_cycle();
        if (wr_fire_prev) wr_idx++;
        cmd_valid = 1'b0;
        HREADY = rdy; HRESP = resp; HRDATA = rdata;
        wr_valid = (wr_idx < wr_total) && !wstall;
        wr_data = wr_base + 32'(wr_idx);
        #2;
        check({tag, ".htrans"}, 32'(HTRANS), 32'(e_trans));
        check({tag, ".haddr"}, HADDR, e_addr);
        if (e_wd_chk) check({tag, ".hwdata"}, HWDATA, e_wd);
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_rdv));
        if (e_rdv) check({tag, ".rd_data"}, rd_data, e_rd);
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".err"}, 32'(err), 32'(e_err));
        wr_fire_prev = wr_valid && wr_ready;
    endtask

    task automatic reject_case(input string tag, input logic [31:0] addr,
                               input logic [2:0] size, input logic [1:0] len);
        send_cmd(1'b0, addr, size, len, 32'h0);
        next_cycle();
        cmd_valid = 1'b0;
        #2;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".err"}, 32'(err), 32'd1);
        check({tag, ".htrans"}, 32'(HTRANS), 32'd0);
        next_cycle();
        #2;
        check({tag, ".done_end"}, 32'(done), 32'd0);
        check({tag, ".htrans_end"}, 32'(HTRANS), 32'd0);
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        $display("txn %s: rejected command addr=0x%08h size=%0d len=%0d", tag, addr, size, len);
    endtask

    initial begin
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_size = 3'd0; cmd_len = 2'd0; wr_valid = 1'b0; wr_data = 32'h0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        wr_idx = 0; wr_total = 0; wr_base = 32'h0; wr_fire_prev = 1'b0;

        next_cycle();
        next_cycle();
        #2;
        check("rst.htrans", 32'(HTRANS), 32'd0);
        check("rst.haddr", HADDR, 32'h0);
        check("rst.hwrite", 32'(HWRITE), 32'd0);
        check("rst.hsize", 32'(HSIZE), 32'd0);
        check("rst.hburst", 32'(HBURST), 32'd0);
        check("rst.hprot", 32'(HPROT), 32'h3);
        check("rst.hwdata", HWDATA, 32'h0);
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst.wr_ready", 32'(wr_ready), 32'd0);
        check("rst.rd_valid", 32'(rd_valid), 32'd0);
        check("rst.rd_data", rd_data, 32'h0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        next_cycle();
        HRESET = 1'b0;

        // SINGLE read at 0x100
        send_cmd(1'b0, 32'h100, 3'd2, 2'd0, 32'h0);
        bus_cycle("rs.c0", 1, 0, 32'h0,        0, 2'd2, 32'h100, 0, 0, 0, 0,            0, 0);
        check("rs.hburst", 32'(HBURST), 32'd0);
        check("rs.hsize", 32'(HSIZE), 32'd2);
        check("rs.hwrite", 32'(HWRITE), 32'd0);
        bus_cycle("rs.c1", 1, 0, 32'hDEADBEEF, 0, 2'd0, 32'h100, 0, 0, 1, 32'hDEADBEEF, 1, 0);
        $display("txn single read 0x100 complete");

        // INCR4 word write, two wait states on beat 2
        send_cmd(1'b1, 32'h2000, 3'd2, 2'd1, 32'd1);
        bus_cycle("w4.c0", 1, 0, 0, 0, 2'd0, 32'h2000, 0, 0, 0, 0, 0, 0);
        check("w4.wr_ready", 32'(wr_ready), 32'd1);
        check("w4.hburst", 32'(HBURST), 32'b011);
        check("w4.hwrite", 32'(HWRITE), 32'd1);
        bus_cycle("w4.c1", 1, 0, 0, 0, 2'd2, 32'h2000, 0, 0, 0, 0, 0, 0);
        bus_cycle("w4.c2", 1, 0, 0, 0, 2'd3, 32'h2004, 1, 1, 0, 0, 0, 0);
        bus_cycle("w4.c3", 1, 0, 0, 0, 2'd3, 32'h2008, 1, 2, 0, 0, 0, 0);
        bus_cycle("w4.c4", 0, 0, 0, 0, 2'd3, 32'h200C, 1, 3, 0, 0, 0, 0);
        bus_cycle("w4.c5", 0, 0, 0, 0, 2'd3, 32'h200C, 1, 3, 0, 0, 0, 0);
        bus_cycle("w4.c6", 1, 0, 0, 0, 2'd3, 32'h200C, 1, 3, 0, 0, 0, 0);
        bus_cycle("w4.c7", 1, 0, 0, 0, 2'd0, 32'h200C, 1, 4, 0, 0, 1, 0);
        $display("txn INCR4 write 0x2000 complete");

        // INCR8 halfword write, wr_valid withheld for three cycles after beat 3
        send_cmd(1'b1, 32'h3000, 3'd1, 2'd2, 32'hA0);
        bus_cycle("w8.c0",  1, 0, 0, 0, 2'd0, 32'h3000, 0, 0,      0, 0, 0, 0);
        check("w8.hburst", 32'(HBURST), 32'b101);
        bus_cycle("w8.c1",  1, 0, 0, 0, 2'd2, 32'h3000, 0, 0,      0, 0, 0, 0);
        bus_cycle("w8.c2",  1, 0, 0, 0, 2'd3, 32'h3002, 1, 32'hA0, 0, 0, 0, 0);
        bus_cycle("w8.c3",  1, 0, 0, 0, 2'd3, 32'h3004, 1, 32'hA1, 0, 0, 0, 0);
        bus_cycle("w8.c4",  1, 0, 0, 1, 2'd3, 32'h3006, 1, 32'hA2, 0, 0, 0, 0);
        bus_cycle("w8.c5",  1, 0, 0, 1, 2'd1, 32'h3008, 1, 32'hA3, 0, 0, 0, 0);
        bus_cycle("w8.c6",  1, 0, 0, 1, 2'd1, 32'h3008, 1, 32'hA3, 0, 0, 0, 0);
        bus_cycle("w8.c7",  1, 0, 0, 0, 2'd1, 32'h3008, 1, 32'hA3, 0, 0, 0, 0);
        bus_cycle("w8.c8",  1, 0, 0, 0, 2'd3, 32'h3008, 1, 32'hA3, 0, 0, 0, 0);
        bus_cycle("w8.c9",  1, 0, 0, 0, 2'd3, 32'h300A, 1, 32'hA4, 0, 0, 0, 0);
        bus_cycle("w8.c10", 1, 0, 0, 0, 2'd3, 32'h300C, 1, 32'hA5, 0, 0, 0, 0);
        bus_cycle("w8.c11", 1, 0, 0, 0, 2'd3, 32'h300E, 1, 32'hA6, 0, 0, 0, 0);
        bus_cycle("w8.c12", 1, 0, 0, 0, 2'd0, 32'h300E, 1, 32'hA7, 0, 0, 1, 0);
        $display("txn INCR8 write 0x3000 with BUSY complete");

        // INCR16 read, ERROR on beat 5
        send_cmd(1'b0, 32'h400, 3'd2, 2'd3, 32'h0);
        bus_cycle("r16.c0", 1, 0, 32'h0,   0, 2'd2, 32'h400, 0, 0, 0, 0,       0, 0);
        check("r16.hburst", 32'(HBURST), 32'b111);
        bus_cycle("r16.c1", 1, 0, 32'h100, 0, 2'd3, 32'h404, 0, 0, 1, 32'h100, 0, 0);
        bus_cycle("r16.c2", 1, 0, 32'h101, 0, 2'd3, 32'h408, 0, 0, 1, 32'h101, 0, 0);
        bus_cycle("r16.c3", 1, 0, 32'h102, 0, 2'd3, 32'h40C, 0, 0, 1, 32'h102, 0, 0);
        bus_cycle("r16.c4", 1, 0, 32'h103, 0, 2'd3, 32'h410, 0, 0, 1, 32'h103, 0, 0);
        bus_cycle("r16.c5", 1, 0, 32'h104, 0, 2'd3, 32'h414, 0, 0, 1, 32'h104, 0, 0);
        bus_cycle("r16.c6", 0, 1, 32'h105, 0, 2'd3, 32'h418, 0, 0, 0, 0,       0, 0);
        bus_cycle("r16.c7", 1, 1, 32'h106, 0, 2'd0, 32'h418, 0, 0, 0, 0,       1, 1);
        bus_cycle("r16.c8", 1, 0, 32'h0,   0, 2'd0, 32'h418, 0, 0, 0, 0,       0, 0);
        check("r16.cmd_ready", 32'(cmd_ready), 32'd1);
        $display("txn INCR16 read 0x400 terminated by ERROR");

        // INCR4 ending exactly on the 1 KB boundary is legal
        send_cmd(1'b0, 32'h3F0, 3'd2, 2'd1, 32'h0);
        bus_cycle("bnd.c0", 1, 0, 32'h0,   0, 2'd2, 32'h3F0, 0, 0, 0, 0,       0, 0);
        bus_cycle("bnd.c1", 1, 0, 32'h200, 0, 2'd3, 32'h3F4, 0, 0, 1, 32'h200, 0, 0);
        bus_cycle("bnd.c2", 1, 0, 32'h201, 0, 2'd3, 32'h3F8, 0, 0, 1, 32'h201, 0, 0);
        bus_cycle("bnd.c3", 1, 0, 32'h202, 0, 2'd3, 32'h3FC, 0, 0, 1, 32'h202, 0, 0);
        bus_cycle("bnd.c4", 1, 0, 32'h203, 0, 2'd0, 32'h3FC, 0, 0, 1, 32'h203, 1, 0);
        $display("txn INCR4 read 0x3F0 complete");

        reject_case("rej1k", 32'h3F8, 3'd2, 2'd1);
        reject_case("rejsz", 32'h0, 3'd3, 2'd0);

        // Reset during beat 6 of an INCR8 read, then a fresh SINGLE read
        send_cmd(1'b0, 32'h500, 3'd2, 2'd2, 32'h0);
        bus_cycle("rr.c0", 1, 0, 32'h0,   0, 2'd2, 32'h500, 0, 0, 0, 0,       0, 0);
        bus_cycle("rr.c1", 1, 0, 32'h300, 0, 2'd3, 32'h504, 0, 0, 1, 32'h300, 0, 0);
        bus_cycle("rr.c2", 1, 0, 32'h301, 0, 2'd3, 32'h508, 0, 0, 1, 32'h301, 0, 0);
        bus_cycle("rr.c3", 1, 0, 32'h302, 0, 2'd3, 32'h50C, 0, 0, 1, 32'h302, 0, 0);
        bus_cycle("rr.c4", 1, 0, 32'h303, 0, 2'd3, 32'h510, 0, 0, 1, 32'h303, 0, 0);
        bus_cycle("rr.c5", 1, 0, 32'h304, 0, 2'd3, 32'h514, 0, 0, 1, 32'h304, 0, 0);
        bus_cycle("rr.c6", 1, 0, 32'h305, 0, 2'd3, 32'h518, 0, 0, 1, 32'h305, 0, 0);
        HRESET = 1'b1;
        next_cycle();
        HRESET = 1'b0;
        #2;
        check("rr.htrans", 32'(HTRANS), 32'd0);
        check("rr.haddr", HADDR, 32'h0);
        check("rr.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rr.done", 32'(done), 32'd0);
        check("rr.rd_valid", 32'(rd_valid), 32'd0);
        $display("txn INCR8 read 0x500 aborted by reset");
        send_cmd(1'b0, 32'h104, 3'd2, 2'd0, 32'h0);
        bus_cycle("rr.s0", 1, 0, 32'h0,        0, 2'd2, 32'h104, 0, 0, 0, 0,            0, 0);
        bus_cycle("rr.s1", 1, 0, 32'hCAFEF00D, 0, 2'd0, 32'h104, 0, 0, 1, 32'hCAFEF00D, 1, 0);
        $display("txn single read 0x104 after reset complete");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
